// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display scan controller
package display_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;
endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - per-digit slot counter and blank/show sequencing
module scan_timer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic clk,
    input  logic reset,
    output logic show_start,
    output logic slot_end,
    output logic is_show
);
    logic [CNT_W-1:0] cnt;
    scan_state_t      state;

    assign slot_end   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign show_start = (state == S_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign is_show    = (state == S_SHOW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            state <= S_BLANK;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (show_start) begin
                state <= S_SHOW;
            end else if (is_show && slot_end) begin
                state <= S_BLANK;
            end
        end
    end
endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - double-buffered 8-digit BCD scan with blanking and LZB
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [31:0] frame_data,
    output logic        frame_ready,
    input  logic [7:0]  digit_mask,
    input  logic        lzb_en,
    output logic [2:0]  anum,
    output logic [3:0]  bcd,
    output logic        blank,
    output logic        frame_done
);
    logic [FRAME_W-1:0] active;
    logic [FRAME_W-1:0] shadow;
    logic               shadow_full;
    logic               show_start;
    logic               slot_end;
    logic               is_show;
    logic               boundary;
    logic               transfer;
    logic               next_show;
    logic [DIGIT_W-1:0] digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz;
    logic               zero_run;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_scan_timer (
        .clk        (clk),
        .reset      (reset),
        .show_start (show_start),
        .slot_end   (slot_end),
        .is_show    (is_show)
    );

    assign frame_ready = !shadow_full;
    assign transfer    = frame_valid && frame_ready;
    assign boundary    = is_show && slot_end && (anum == 3'd7);
    // Outputs are registered, so they are loaded from the state the timer is about to enter.
    assign next_show   = show_start || (is_show && !slot_end);

    // Leading-zero flags scan from the most significant digit down; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit[i] = active[i*DIGIT_W +: DIGIT_W];
            zero_run = zero_run && (digit[i] == BCD_ZERO);
            lz[i]    = lzb_en && zero_run && (i != 0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active      <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            anum        <= 3'd0;
            bcd         <= BCD_ZERO;
            blank       <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (is_show && slot_end) begin
                anum <= anum + 3'd1;
            end
            if (next_show) begin
                bcd   <= digit[anum];
                blank <= !digit_mask[anum] || lz[anum];
            end else begin
                bcd   <= BCD_ZERO;
                blank <= 1'b1;
            end
            if (boundary && shadow_full) begin
                active <= shadow;
            end
            // A transfer on the boundary edge refills the shadow and waits for the next frame.
            if (transfer) begin
                shadow      <= frame_data;
                shadow_full <= 1'b1;
            end else if (boundary) begin
                shadow_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic [31:0] frame_data = 32'd0;
    logic        frame_ready;
    logic [7:0]  digit_mask = 8'hFF;
    logic        lzb_en = 1'b0;
    logic [2:0]  anum;
    logic [3:0]  bcd;
    logic        blank;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_active;
    logic [31:0] m_shadow;
    bit          m_full;
    logic [7:0]  p_mask;
    bit          p_lzb;
    int          t;

    display_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .CNT_W        (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .digit_mask  (digit_mask),
        .lzb_en      (lzb_en),
        .anum        (anum),
        .bcd         (bcd),
        .blank       (blank),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, t);
        end
    endtask

    function automatic bit m_lz(input logic [31:0] f, input bit en, input int i);
        if (!en || i == 0) return 1'b0;
        for (int j = i; j < 8; j++) begin
            if (f[j*4 +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One cycle: compare against the slot/position model, then advance the model past the edge.
    task automatic step();
        int  slot;
        int  pos;
        bit  show;
        bit  xfer;
        bit  bnd;
        slot = (t / 8) % 8;
        pos  = t % 8;
        show = (pos >= 2);
        chk("anum", {29'd0, anum}, slot);
        chk("bcd", {28'd0, bcd}, show ? {28'd0, m_active[slot*4 +: 4]} : 32'd0);
        chk("blank", {31'd0, blank}, show ? {31'd0, (!p_mask[slot] || m_lz(m_active, p_lzb, slot))} : 32'd1);
        chk("frame_done", {31'd0, frame_done}, {31'd0, (t != 0 && t % 64 == 0)});
        chk("frame_ready", {31'd0, frame_ready}, {31'd0, !m_full});
        @(posedge clk);
        #1;
        xfer = frame_valid && !m_full;
        bnd  = (t % 64) == 63;
        if (bnd && m_full) begin
            m_active = m_shadow;
            m_full   = 1'b0;
        end
        if (xfer) begin
            m_shadow = frame_data;
            m_full   = 1'b1;
        end
        p_mask = digit_mask;
        p_lzb  = lzb_en;
        t++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        frame_valid = 1'b0;
        #1;
        chk("rst_anum", {29'd0, anum}, 32'd0);
        chk("rst_blank", {31'd0, blank}, 32'd1);
        chk("rst_bcd", {28'd0, bcd}, 32'd0);
        chk("rst_ready", {31'd0, frame_ready}, 32'd1);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_active = 32'd0;
        m_shadow = 32'd0;
        m_full   = 1'b0;
        p_mask   = digit_mask;
        p_lzb    = lzb_en;
        t        = 0;
    endtask

    initial begin
        t = 0;
        @(posedge clk);
        #1;

        // Idle scan of an all-zero frame
        digit_mask = 8'hFF;
        lzb_en     = 1'b0;
        do_reset();
        run(70);

        // Single frame offered mid-slot
        do_reset();
        run(5);
        frame_valid = 1'b1;
        frame_data  = 32'h87654321;
        run(1);
        frame_valid = 1'b0;
        frame_data  = 32'hDEADBEEF;
        run(130);

        // Back-to-back frames with valid held
        do_reset();
        frame_valid = 1'b1;
        frame_data  = 32'h11111111;
        run(1);
        frame_data  = 32'h22222222;
        run(70);
        frame_valid = 1'b0;
        run(70);

        // Leading-zero blanking
        lzb_en = 1'b1;
        do_reset();
        run(70);
        frame_valid = 1'b1;
        frame_data  = 32'h00000405;
        run(1);
        frame_valid = 1'b0;
        run(130);
        lzb_en = 1'b0;

        // Digit mask hides slot 3 only
        digit_mask = 8'b1111_0111;
        do_reset();
        frame_valid = 1'b1;
        frame_data  = 32'h9A7B5C3D;
        run(1);
        frame_valid = 1'b0;
        run(130);
        digit_mask = 8'hFF;

        // Reset mid-frame discards a pending shadow frame
        do_reset();
        frame_valid = 1'b1;
        frame_data  = 32'h99999999;
        run(1);
        frame_valid = 1'b0;
        run(29);
        do_reset();
        run(140);

        // Randomised traffic, masks and blanking enable
        do_reset();
        for (int k = 0; k < 900; k++) begin
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_data  = $urandom >> (4 * $urandom_range(0, 8));
            digit_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes the single BCD-to-seven-segment decoder across the 8 stopwatch digits.
- Holds a double-buffered 8-digit BCD frame and steps the anode index 0..7 at a programmable refresh rate.
- Inserts a blanking interval between digits to suppress ghosting, and applies leading-zero blanking and a per-digit enable mask.
- Accepts new frames from the stopwatch counter over a valid/ready handshake. Frames commit only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (blank + show); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot during which `blank` = 1; must be ≥ 1.
- CNT_W, 17, width of the slot counter; must hold REFRESH_DIV-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_valid  in  1  the frame_data word is offered.
- frame_data  in  32  8 BCD digits; digit i is at [4i+3:4i]; digit 0 is rightmost.
- frame_ready  out  1  the shadow buffer is empty, so a frame can be accepted.
- digit_mask  in  8  bit i = 1 enables digit i; a 0 bit forces blank for that slot.
- lzb_en  in  1  leading-zero blanking enable.
- anum  out  3  anode index for the decoder.
- bcd  out  4  digit value for the decoder.
- blank  out  1  1 = the top level drives all anodes off (an = 8'hFF).
- frame_done  out  1  one-cycle pulse when the 7->0 wrap occurs.

Behaviour:
- Reset values: active frame = 0, shadow_full = 0, anum = 0, slot counter = 0, state = S_BLANK, blank = 1, bcd = 0, frame_done = 0. frame_ready = !shadow_full, so it is 1 during and after reset.
- Reset asserted mid-frame aborts the scan immediately. Any shadow frame is discarded.
- The slot counter counts 0..REFRESH_DIV-1 and then wraps to 0.
- FSM transitions:
  - S_BLANK -> S_SHOW when counter == BLANK_CYCLES-1.
  - S_SHOW -> S_BLANK when counter == REFRESH_DIV-1; anum increments mod 8 on the same edge.
- Each slot is BLANK_CYCLES blank cycles followed by REFRESH_DIV - BLANK_CYCLES show cycles. One frame lasts 8 × REFRESH_DIV cycles.
- Outputs are registered. In S_BLANK: blank = 1, bcd = 0.
- In S_SHOW: bcd = active[anum], and blank = !digit_mask[anum] | lz[anum].
- Leading-zero flags: lz[i] = lzb_en & (all active digits 7..i equal 0) & (i != 0). Digit 0 is never leading-zero blanked.
- Handshake: a transfer occurs when frame_valid & frame_ready on a rising edge. On transfer, shadow <= frame_data and shadow_full <= 1. frame_data may change freely when no transfer occurs.
- Frame boundary is the edge where anum goes 7->0. On that edge:
  - frame_done pulses for 1 cycle.
  - If shadow_full: active <= shadow and shadow_full <= 0.
- Transfer and boundary on the same edge: the transfer loads the shadow, which was empty because ready = 1. That data commits at the next boundary, not this one.
- Data is never lost. When the shadow is full, frame_ready = 0 until the next boundary.
- BCD digits > 9 pass through unchanged; the decoder handles them. No error is flagged.
- digit_mask and lzb_en are sampled every cycle with no latching.

Decomposition:
- Shared package `display_pkg` holds:
  - the state enum {S_BLANK, S_SHOW};
  - NUM_DIGITS = 8;
  - DIGIT_W = 4;
  - the BCD_ZERO constant.
- One sub-module, `scan_timer`: the slot counter plus the blank/show FSM. It emits show_start, slot_end and is_show; the parent owns anum, the buffers and the handshake.

Test Plan:
All scenarios use REFRESH_DIV = 8, BLANK_CYCLES = 2.
1. Reset then idle, frame = 0, mask = FF, lzb_en = 0:
   - cycles 0–1: anum = 0, blank = 1;
   - cycles 2–7: blank = 0, bcd = 0;
   - cycle 8: anum = 1, blank = 1;
   - frame_done pulses at cycle 64.
2. Offer frame_data = 0x87654321 at cycle 5:
   - frame_ready drops at cycle 6;
   - display shows 0 until cycle 64;
   - from cycle 66 slot 0 shows bcd = 1, and slot 7 shows bcd = 8 at cycles 122–127;
   - frame_ready returns to 1 at cycle 64.
3. Back-to-back frames A = 0x11111111 and B = 0x22222222 with valid held high:
   - A is accepted immediately;
   - B stalls with ready = 0 until the boundary, is accepted at cycle 65, and displays from cycle 128 onward.
4. Frame 0x00000405 with lzb_en = 1:
   - digits 7..3 stay blank in show;
   - digit 2 shows 4, digit 1 shows 0, digit 0 shows 5.
   - Frame 0 with lzb_en = 1: only digit 0 is unblanked.
5. digit_mask = 8'b1111_0111: the slot-3 show window keeps blank = 1; all other slots are unaffected.
6. Assert reset at cycle 30 with a pending shadow frame:
   - anum = 0, blank = 1, frame_ready = 1 immediately;
   - after release, timing restarts from cycle 0 and the pending frame never appears.
